// File: rtl/dsp_capture_buffer_if.sv
// Bus bundle for dsp_capture_buffer: sample stream, capture control, CPU read port and status.
// The capture engine connects as slave; the controlling/producing side as master.
interface dsp_capture_buffer_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic                 s_valid;
    logic signed [DW-1:0] s_x;
    logic signed [DW-1:0] s_y;
    logic                 arm;
    logic                 abort;
    logic                 sw_trigger;
    logic [1:0]           trig_mode;
    logic signed [DW-1:0] trig_level;
    logic [AW:0]          num_samples;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [2*DW-1:0]      rd_data;
    logic                 rd_valid;
    logic [1:0]           state;
    logic                 busy;
    logic                 done;
    logic [AW:0]          sample_count;

    modport master (
        output s_valid, s_x, s_y, arm, abort, sw_trigger, trig_mode, trig_level,
               num_samples, rd_en, rd_addr,
        input  rd_data, rd_valid, state, busy, done, sample_count
    );

    modport slave (
        input  s_valid, s_x, s_y, arm, abort, sw_trigger, trig_mode, trig_level,
               num_samples, rd_en, rd_addr,
        output rd_data, rd_valid, state, busy, done, sample_count
    );
endinterface

// File: rtl/dsp_capture_buffer.sv
// Triggered I/Q capture buffer: records the ce-qualified downsampler stream into block RAM
// after a trigger and lets the CPU read it back through a registered address/strobe port.
module dsp_capture_buffer #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic              sys_clk,
    input  logic              rst,
    dsp_capture_buffer_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};

    logic [1:0]           cur_state;
    logic [AW:0]          count;
    logic [AW:0]          len;
    logic                 trig_pending;
    logic                 prev_valid;
    logic signed [DW-1:0] prev_x;
    logic [AW:0]          arm_len;
    logic                 fire;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;

    logic [2*DW-1:0] mem [0:(1<<AW)-1];

    // Zero means "whole buffer"; anything larger than the RAM is clamped to it.
    always_comb begin
        arm_len = bus.num_samples;
        if (bus.num_samples == '0 || bus.num_samples > MAX_LEN)
            arm_len = MAX_LEN;
    end

    always_comb begin
        fire = 1'b0;
        if (bus.s_valid) begin
            case (bus.trig_mode)
                2'd1:    fire = trig_pending || bus.sw_trigger;
                2'd2:    fire = prev_valid && ($signed(prev_x) < $signed(bus.trig_level))
                                && ($signed(bus.s_x) >= $signed(bus.trig_level));
                default: fire = 1'b1;
            endcase
        end
    end

    // A cycle carrying arm or abort never writes, so a restart cannot leave a stray sample.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (!bus.abort && !bus.arm) begin
            if (cur_state == ST_ARMED && fire) begin
                wr_en = 1'b1;
            end else if (cur_state == ST_CAPTURE && bus.s_valid) begin
                wr_en   = 1'b1;
                wr_addr = count[AW-1:0];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cur_state    <= ST_IDLE;
            count        <= '0;
            len          <= MAX_LEN;
            trig_pending <= 1'b0;
            prev_valid   <= 1'b0;
            prev_x       <= '0;
        end else if (bus.abort) begin
            cur_state <= ST_IDLE;
        end else if (bus.arm) begin
            cur_state    <= ST_ARMED;
            count        <= '0;
            len          <= arm_len;
            trig_pending <= 1'b0;
            prev_valid   <= 1'b0;
        end else begin
            case (cur_state)
                ST_ARMED: begin
                    if (bus.sw_trigger)
                        trig_pending <= 1'b1;
                    if (bus.s_valid) begin
                        prev_x     <= bus.s_x;
                        prev_valid <= 1'b1;
                        if (fire) begin
                            count     <= ONE;
                            cur_state <= (len == ONE) ? ST_DONE : ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (bus.s_valid) begin
                        count <= count + ONE;
                        if (count + ONE == len)
                            cur_state <= ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM has no reset; non-blocking write gives read-first behaviour on address collisions.
    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[wr_addr] <= {bus.s_y, bus.s_x};
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en)
                bus.rd_data <= mem[bus.rd_addr];
        end
    end

    assign bus.state        = cur_state;
    assign bus.busy         = (cur_state == ST_ARMED) || (cur_state == ST_CAPTURE);
    assign bus.done         = (cur_state == ST_DONE);
    assign bus.sample_count = count;
endmodule

// File: tb/tb_dsp_capture_buffer.sv
// Self-checking bench for dsp_capture_buffer: directed vector table, hand-written corner
// sequences and randomized captures compared against a queue-based capture model.
module tb_dsp_capture_buffer;
    logic sys_clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    dsp_capture_buffer_if #(.DW(16), .AW(10)) bus ();

    dsp_capture_buffer #(.DW(16), .AW(10)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]       mode;
        int               num;
        int               level;
        int               gap;
        logic [5:0][15:0] xs;
        logic [1:0]       exp_state;
        int               exp_count;
        logic [15:0]      exp_x0;
        logic [15:0]      exp_x1;
    } vec_t;

    vec_t vecs [7];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [15:0] x, input logic [15:0] y, input logic sw);
        bus.s_valid    = v;
        bus.s_x        = x;
        bus.s_y        = y;
        bus.sw_trigger = sw;
        tick();
        bus.s_valid    = 1'b0;
        bus.sw_trigger = 1'b0;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;
        bus.rd_en      = 1'b0;
    endtask

    // Length is latched at arm, so num_samples is scrambled right afterwards.
    task automatic arm_capture(input logic [1:0] mode, input int num);
        bus.trig_mode   = mode;
        bus.num_samples = 11'(num);
        bus.arm         = 1'b1;
        tick();
        bus.arm         = 1'b0;
        bus.num_samples = 11'd1;
    endtask

    task automatic abort_capture();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic do_read(input int addr, input logic [31:0] exp, input string name);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 10'(addr);
        tick();
        bus.rd_en   = 1'b0;
        check_output({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check_output(name, bus.rd_data, exp);
        tick();
        check_output({name, "_valid_drop"}, 32'(bus.rd_valid), 32'd0);
    endtask

    task automatic check_status(input string name, input logic [1:0] st, input int cnt);
        check_output({name, "_state"}, 32'(bus.state), 32'(st));
        check_output({name, "_count"}, 32'(bus.sample_count), 32'(cnt));
        check_output({name, "_busy"}, 32'(bus.busy), 32'(st == 2'd1 || st == 2'd2));
        check_output({name, "_done"}, 32'(bus.done), 32'(st == 2'd3));
    endtask

    function automatic vec_t mk(input logic [1:0] mode, input int num, input int level, input int gap,
                                input int a, input int b, input int c, input int d, input int e,
                                input int f, input logic [1:0] st, input int cnt, input int x0,
                                input int x1);
        vec_t v;
        v.mode = mode; v.num = num; v.level = level; v.gap = gap;
        v.xs[0] = 16'(a); v.xs[1] = 16'(b); v.xs[2] = 16'(c);
        v.xs[3] = 16'(d); v.xs[4] = 16'(e); v.xs[5] = 16'(f);
        v.exp_state = st; v.exp_count = cnt; v.exp_x0 = 16'(x0); v.exp_x1 = 16'(x1);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] x;
        int          q_x [$];
        int          q_y [$];
        int          q_c [$];

        rst = 1'b1;
        bus.s_valid = 0; bus.s_x = 0; bus.s_y = 0; bus.arm = 0; bus.abort = 0;
        bus.sw_trigger = 0; bus.trig_mode = 0; bus.trig_level = 0; bus.num_samples = 0;
        bus.rd_en = 0; bus.rd_addr = 0;
        #2;
        check_status("reset", 2'd0, 0);
        check_output("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        check_output("reset_rd_data", bus.rd_data, 32'd0);
        tick(); tick();
        rst = 1'b0;

        vecs[0] = mk(2'd0, 6, 0, 0, 10, 11, 12, 13, 14, 15, 2'd3, 6, 10, 11);
        vecs[1] = mk(2'd2, 2, 100, 1, 150, 90, 95, 100, 120, 130, 2'd3, 2, 100, 120);
        vecs[2] = mk(2'd3, 3, 0, 0, 5, 6, 7, 8, 9, 10, 2'd3, 3, 5, 6);
        vecs[3] = mk(2'd2, 8, -5, 0, -10, -6, -5, 3, 4, 5, 2'd2, 4, -5, 3);
        vecs[4] = mk(2'd2, 4, 50, 0, 60, 70, 80, 90, 100, 110, 2'd1, 0, 0, 0);
        vecs[5] = mk(2'd1, 4, 0, 0, 1, 2, 3, 4, 5, 6, 2'd1, 0, 0, 0);
        vecs[6] = mk(2'd0, 1, 0, 0, 42, 43, 44, 45, 46, 47, 2'd3, 1, 42, 0);

        foreach (vecs[i]) begin
            abort_capture();
            bus.trig_level = 16'(vecs[i].level);
            arm_capture(vecs[i].mode, vecs[i].num);
            for (int k = 0; k < 6; k++) begin
                x = vecs[i].xs[k];
                apply_stimulus(1'b1, x, 16'd0 - x, 1'b0);
                for (int g = 0; g < vecs[i].gap; g++) apply_stimulus(1'b0, 16'd0, 16'd0, 1'b0);
            end
            check_status($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_count);
            if (vecs[i].exp_count >= 1)
                do_read(0, {16'd0 - vecs[i].exp_x0, vecs[i].exp_x0}, $sformatf("vec%0d_a0", i));
            if (vecs[i].exp_count >= 2)
                do_read(1, {16'd0 - vecs[i].exp_x1, vecs[i].exp_x1}, $sformatf("vec%0d_a1", i));
        end

        // Mode 0, N=4, one sample every third cycle; addr1 read collides with its own write.
        abort_capture();
        arm_capture(2'd0, 4);
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(1'b0, 16'd0, 16'd0, 1'b0);
            apply_stimulus(1'b0, 16'd0, 16'd0, 1'b0);
            if (k == 2) begin
                bus.rd_en = 1'b1;
                bus.rd_addr = 10'd1;
            end
            apply_stimulus(1'b1, 16'(k), 16'(-k), 1'b0);
            if (k == 2) check_output("read_first", bus.rd_data, {16'hFFFD, 16'h0003});
            if (k == 3) check_status("m0_after3", 2'd2, 3);
            if (k == 4) check_status("m0_after4", 2'd3, 4);
        end
        check_status("m0_after5", 2'd3, 4);
        for (int k = 0; k < 4; k++)
            do_read(k, {16'(-(k + 1)), 16'(k + 1)}, $sformatf("m0_a%0d", k));
        do_read(4, {16'(-14), 16'd14}, "m0_a4_untouched");

        // Software trigger coinciding with the sample, then a stale IDLE trigger.
        abort_capture();
        arm_capture(2'd1, 3);
        apply_stimulus(1'b0, 16'd0, 16'd0, 1'b0);
        apply_stimulus(1'b1, 16'd7, 16'(-7), 1'b1);
        check_status("sw_same", 2'd2, 1);
        do_read(0, {16'(-7), 16'd7}, "sw_same_a0");
        abort_capture();
        apply_stimulus(1'b0, 16'd0, 16'd0, 1'b1);
        arm_capture(2'd1, 3);
        for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 16'(20 + k), 16'd0, 1'b0);
        check_status("sw_stale", 2'd1, 0);
        apply_stimulus(1'b0, 16'd0, 16'd0, 1'b1);
        apply_stimulus(1'b0, 16'd0, 16'd0, 1'b0);
        apply_stimulus(1'b1, 16'd33, 16'(-33), 1'b0);
        check_status("sw_pending", 2'd2, 1);
        do_read(0, {16'(-33), 16'd33}, "sw_pending_a0");

        // Full-depth captures: zero length and an oversize length both mean 1024.
        for (int r = 0; r < 2; r++) begin
            abort_capture();
            arm_capture(2'd0, (r == 0) ? 0 : 1500);
            for (int k = 0; k < 1023; k++) apply_stimulus(1'b1, 16'(k), 16'(k) ^ 16'h5A5A, 1'b0);
            check_status($sformatf("full%0d_1023", r), 2'd2, 1023);
            apply_stimulus(1'b1, 16'd1023, 16'd1023 ^ 16'h5A5A, 1'b0);
            check_status($sformatf("full%0d_1024", r), 2'd3, 1024);
            for (int k = 0; k < 3; k++) apply_stimulus(1'b1, 16'hBEEF, 16'hBEEF, 1'b0);
            check_status($sformatf("full%0d_hold", r), 2'd3, 1024);
        end
        do_read(0, {16'h5A5A, 16'd0}, "full_a0");
        do_read(512, {16'd512 ^ 16'h5A5A, 16'd512}, "full_a512");
        do_read(1023, {16'd1023 ^ 16'h5A5A, 16'd1023}, "full_a1023");

        // Abort and arm together: abort wins, count is kept, the sample is dropped.
        abort_capture();
        arm_capture(2'd0, 10);
        for (int k = 0; k < 5; k++) apply_stimulus(1'b1, 16'(50 + k), 16'd0, 1'b0);
        check_status("abort_pre", 2'd2, 5);
        bus.abort = 1'b1;
        bus.arm = 1'b1;
        apply_stimulus(1'b1, 16'd99, 16'd99, 1'b0);
        check_status("abort_arm", 2'd0, 5);
        arm_capture(2'd0, 10);
        check_status("rearm", 2'd1, 0);
        do_read(5, {16'd5 ^ 16'h5A5A, 16'd5}, "abort_a5");

        // Randomized captures against the queue model.
        for (int it = 0; it < 25; it++) begin
            logic [1:0] mode;
            logic [1:0] exp_st;
            int n, level, sw_cyc, trig, exp_cnt;
            mode   = 2'($urandom_range(0, 3));
            n      = int'($urandom_range(1, 12));
            level  = int'($urandom_range(0, 40)) - 20;
            sw_cyc = int'($urandom_range(0, 30));
            q_x.delete(); q_y.delete(); q_c.delete();
            abort_capture();
            bus.trig_level = 16'(level);
            arm_capture(mode, n);
            for (int c = 0; c < 50; c++) begin
                logic v;
                int xv, yv;
                v  = ($urandom_range(0, 2) != 0);
                xv = int'($urandom_range(0, 60)) - 30;
                yv = int'($urandom_range(0, 65535));
                apply_stimulus(v, 16'(xv), 16'(yv), c == sw_cyc);
                if (v) begin
                    q_x.push_back(xv); q_y.push_back(yv); q_c.push_back(c);
                end
            end
            trig = -1;
            for (int k = 0; k < q_x.size() && trig < 0; k++) begin
                case (mode)
                    2'd1:    if (q_c[k] >= sw_cyc) trig = k;
                    2'd2:    if (k >= 1 && q_x[k-1] < level && q_x[k] >= level) trig = k;
                    default: trig = k;
                endcase
            end
            exp_cnt = 0;
            if (trig >= 0) exp_cnt = (q_x.size() - trig < n) ? q_x.size() - trig : n;
            if (trig < 0)         exp_st = 2'd1;
            else if (exp_cnt == n) exp_st = 2'd3;
            else                  exp_st = 2'd2;
            check_status($sformatf("rnd%0d_m%0d", it, mode), exp_st, exp_cnt);
            for (int k = 0; k < exp_cnt; k++)
                do_read(k, {16'(q_y[trig + k]), 16'(q_x[trig + k])}, $sformatf("rnd%0d_a%0d", it, k));
        end

        // Asynchronous reset in the middle of a capture; RAM keeps what was written.
        abort_capture();
        arm_capture(2'd0, 10);
        for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 16'(200 + k), 16'(-(200 + k)), 1'b0);
        do_read(0, {16'(-200), 16'd200}, "prerst_a0");
        #3;
        rst = 1'b1;
        #1;
        check_status("async_rst", 2'd0, 0);
        check_output("async_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check_output("async_rst_rd_data", bus.rd_data, 32'd0);
        tick();
        rst = 1'b0;
        do_read(2, {16'(-202), 16'd202}, "postrst_a2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
